// File: rtl/wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : wb_arbiter                                                      |
// | Desc     : Round-robin arbiter sharing the regfile write port between      |
// |            NREQ writeback sources, with one registered output stage.       |
// |            Optional macro WB_ARB_STARVE_CNT_EN adds per-requester          |
// |            saturating starvation counters.                                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef REG_ADDR_BUS_WIDTH
`define REG_ADDR_BUS_WIDTH 5
`endif
`ifndef REG_BUS_WIDTH
`define REG_BUS_WIDTH 32
`endif

module wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = `REG_ADDR_BUS_WIDTH,
   parameter int DW   = `REG_BUS_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               kill_i,
   input  logic [NREQ-1:0]    req_valid_i,
   input  logic [NREQ*AW-1:0] req_addr_i,
   input  logic [NREQ*DW-1:0] req_data_i,
   output logic [NREQ-1:0]    req_ready_o,
   output logic [AW-1:0]      waddr_o,
   output logic               we_o,
   output logic [DW-1:0]      wdata_o
`ifdef WB_ARB_STARVE_CNT_EN
   ,
   output logic [NREQ*8-1:0]  starve_cnt_o
`endif
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] r_rr_ptr;
   logic [NREQ-1:0] w_grant;
   logic w_any;
   logic [PW-1:0] w_gidx;
   logic [PW:0] w_sum;
   logic [AW-1:0] w_addr_a [NREQ];
   logic [DW-1:0] w_data_a [NREQ];
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;
   logic r_we;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign w_addr_a[gi] = req_addr_i[gi*AW +: AW];
         assign w_data_a[gi] = req_data_i[gi*DW +: DW];
      end
   endgenerate

   // Rotating priority search starting at r_rr_ptr, wrapping modulo NREQ.
   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      w_gidx  = '0;
      w_sum   = '0;
      if (!kill_i && !rst) begin
         for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ))
               w_sum = w_sum - (PW+1)'(NREQ);
            if (!w_any && req_valid_i[w_sum[PW-1:0]]) begin
               w_any  = 1'b1;
               w_gidx = w_sum[PW-1:0];
            end
         end
         if (w_any)
            w_grant[w_gidx] = 1'b1;
      end
   end

   assign req_ready_o = w_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
      end else if (w_any) begin
         r_rr_ptr <= (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
         r_waddr  <= w_addr_a[w_gidx];
         r_wdata  <= w_data_a[w_gidx];
         // x0 requests retire without touching the regfile.
         r_we     <= (w_addr_a[w_gidx] != '0);
      end else begin
         r_we     <= 1'b0;
      end
   end

   assign we_o    = r_we;
   assign waddr_o = r_waddr;
   assign wdata_o = r_wdata;

`ifdef WB_ARB_STARVE_CNT_EN
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_starve
         logic [7:0] r_cnt;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_cnt <= '0;
            else if (w_grant[gi])
               r_cnt <= '0;
            else if (req_valid_i[gi] && r_cnt != 8'hFF)
               r_cnt <= r_cnt + 8'd1;
         end
         assign starve_cnt_o[gi*8 +: 8] = r_cnt;
      end
   endgenerate
`else
   // Starvation counters are not built in this configuration.
`endif

endmodule

`default_nettype wire
